// File: rtl/fsm_step_ctrl_pkg.sv
// Shared constants and state type for the 7-state ring step controller.
package fsm_step_ctrl_pkg;

  localparam int unsigned NUM_STATES = 7;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned LAST_STATE = 6;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } state_e;

  function automatic logic [STATE_W-1:0] ring_succ(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] n;
    n = s + 3'd1;
    return (s == STATE_W'(LAST_STATE)) ? '0 : n;
  endfunction

endpackage

// File: rtl/fsm_step_ctrl_if.sv
// Bus between the step controller and its environment (config, next-state loop, status).
interface fsm_step_ctrl_if #(
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned LAP_W   = 8
);
  import fsm_step_ctrl_pkg::*;

  logic                  run;
  logic                  cfg_we;
  logic [2:0]            cfg_addr;
  logic [DWELL_W-1:0]    cfg_data;
  logic [STATE_W-1:0]    y_next;
  logic [STATE_W-1:0]    state;
  logic [NUM_STATES-1:0] adv;
  logic [LAP_W-1:0]      lap_count;
  logic                  err;

  modport master (
    output run, cfg_we, cfg_addr, cfg_data, y_next,
    input  state, adv, lap_count, err
  );

  modport slave (
    input  run, cfg_we, cfg_addr, cfg_data, y_next,
    output state, adv, lap_count, err
  );

endinterface

// File: rtl/fsm_dwell_regs.sv
// Seven-entry per-state dwell register file; index 7 writes are dropped.
module fsm_dwell_regs
  import fsm_step_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_W       = 4,
  parameter int unsigned DEFAULT_DWELL = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 we_i,
  input  logic [STATE_W-1:0]                   addr_i,
  input  logic [DWELL_W-1:0]                   data_i,
  output logic [NUM_STATES-1:0][DWELL_W-1:0]   dwell_o
);

  logic [NUM_STATES-1:0][DWELL_W-1:0] dwell_q, dwell_d;

  always_comb begin
    dwell_d = dwell_q;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (we_i && (addr_i == STATE_W'(k))) dwell_d[k] = data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_STATES; k++) dwell_q[k] <= DWELL_W'(DEFAULT_DWELL);
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign dwell_o = dwell_q;

endmodule

// File: rtl/fsm_step_ctrl.sv
// State register, dwell timer, advance strobes, lap counter and illegal-transition flag
// wrapped around the combinational 7-state ring next-state logic.
module fsm_step_ctrl
  import fsm_step_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_W       = 4,
  parameter int unsigned DEFAULT_DWELL = 2,
  parameter int unsigned LAP_W         = 8
) (
  input  logic            clock,
  input  logic            reset,
  fsm_step_ctrl_if.slave  bus
);

  logic [NUM_STATES-1:0][DWELL_W-1:0] dwell;
  state_e                state_q, state_d;
  logic [DWELL_W-1:0]    cnt_q, cnt_d, cur_dwell;
  logic [LAP_W-1:0]      lap_q, lap_d;
  logic                  err_q, err_d;
  logic [NUM_STATES-1:0] adv;
  logic                  y_is7, stay, legal;

  fsm_dwell_regs #(
    .DWELL_W       (DWELL_W),
    .DEFAULT_DWELL (DEFAULT_DWELL)
  ) u_dwell_regs (
    .clock   (clock),
    .reset   (reset),
    .we_i    (bus.cfg_we),
    .addr_i  (bus.cfg_addr),
    .data_i  (bus.cfg_data),
    .dwell_o (dwell)
  );

  // Strobes come straight from registers so the ring logic sees them in the same cycle.
  always_comb begin
    adv       = '0;
    cur_dwell = '0;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (state_q == state_e'(STATE_W'(k))) begin
        cur_dwell = dwell[k];
        adv[k]    = bus.run & ~reset & (cnt_q >= dwell[k]);
      end
    end
  end

  always_comb begin
    y_is7   = (bus.y_next == STATE_W'(NUM_STATES));
    stay    = (bus.y_next == state_q);
    legal   = stay || (bus.y_next == ring_succ(state_q));
    state_d = y_is7 ? S0 : state_e'(bus.y_next);
    err_d   = err_q | ~legal;
    lap_d   = lap_q;
    if ((state_q == S6) && (bus.y_next == '0)) lap_d = lap_q + LAP_W'(1);
    cnt_d = cnt_q;
    if (!stay || y_is7) begin
      cnt_d = '0;
    end else if (bus.run && (cnt_q < cur_dwell)) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S0;
      cnt_q   <= '0;
      lap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      err_q   <= err_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.adv       = adv;
  assign bus.lap_count = lap_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Closed-loop bench: ring next-state logic modelled here, DUT checked against a dwell-time model.
module tb_fsm_step_ctrl;
  import fsm_step_ctrl_pkg::*;

  localparam int unsigned DW  = 4;
  localparam int unsigned LW  = 8;
  localparam int unsigned DEF = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fsm_step_ctrl_if #(.DWELL_W(DW), .LAP_W(LW)) bus ();

  fsm_step_ctrl #(
    .DWELL_W       (DW),
    .DEFAULT_DWELL (DEF),
    .LAP_W         (LW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic          r_run  = 1'b0;
  logic          r_we   = 1'b0;
  logic          r_fe   = 1'b0;
  logic [2:0]    r_addr = '0;
  logic [2:0]    r_fv   = '0;
  logic [DW-1:0] r_data = '0;

  assign bus.run      = r_run;
  assign bus.cfg_we   = r_we;
  assign bus.cfg_addr = r_addr;
  assign bus.cfg_data = r_data;

  function automatic logic [2:0] ring(input logic [2:0] a, input logic [6:0] strobes);
    if (a <= 3'd6) begin
      if (strobes[a]) return (a == 3'd6) ? 3'd0 : a + 3'd1;
    end
    return a;
  endfunction

  always_comb bus.y_next = r_fe ? r_fv : ring(bus.state, bus.adv);

  // Model: current ring position, cycles spent counting there, dwell table, laps, error.
  int m_state, m_time, m_lap, m_err;
  int m_dwell[7];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int exp_adv();
    if (r_run && !reset && (m_time >= m_dwell[m_state])) return 1 << m_state;
    return 0;
  endfunction

  task automatic model_edge();
    int y;
    if (reset) begin
      m_state = 0; m_time = 0; m_lap = 0; m_err = 0;
      foreach (m_dwell[k]) m_dwell[k] = DEF;
      return;
    end
    y = r_fe ? int'(r_fv) : ((exp_adv() != 0) ? (m_state + 1) % 7 : m_state);
    if (!(y == m_state || y == (m_state + 1) % 7)) m_err = 1;
    if (m_state == 6 && y == 0) m_lap = (m_lap + 1) % 256;
    if (y != m_state || y == 7) m_time = 0;
    else if (r_run && m_time < m_dwell[m_state]) m_time++;
    m_state = (y == 7) ? 0 : y;
    if (r_we && r_addr <= 3'd6) m_dwell[r_addr] = int'(r_data);
  endtask

  task automatic drive(input logic rst, input logic run, input logic we, input logic [2:0] addr,
                       input logic [DW-1:0] data, input logic fe, input logic [2:0] fv);
    @(negedge clock);
    reset = rst; r_run = run; r_we = we; r_addr = addr; r_data = data; r_fe = fe; r_fv = fv;
    #1;
  endtask

  task automatic finish_cyc(input string tag);
    chk({tag, " adv"}, 32'(bus.adv), exp_adv());
    chk({tag, " state"}, 32'(bus.state), m_state);
    chk({tag, " lap"}, 32'(bus.lap_count), m_lap);
    chk({tag, " err"}, 32'(bus.err), m_err);
    model_edge();
    @(posedge clock);
  endtask

  task automatic step(input logic rst, input logic run, input logic we, input logic [2:0] addr,
                      input logic [DW-1:0] data, input logic fe, input logic [2:0] fv,
                      input string tag);
    drive(rst, run, we, addr, data, fe, fv);
    finish_cyc(tag);
  endtask

  task automatic run_until(input int st, input int tm, input int lap, input int limit,
                           input string tag);
    int n = 0;
    while (!(m_state == st && m_time == tm && (lap < 0 || m_lap == lap)) && n < limit) begin
      step(0, 1, 0, 0, 0, 0, 0, tag);
      n++;
    end
    chk({tag, " reached"}, 32'(m_state == st && m_time == tm), 32'd1);
  endtask

  typedef struct {
    logic       run;
    logic [2:0] st;
    logic [6:0] adv;
    logic [7:0] lap;
  } vec_t;

  vec_t tbl[22];

  initial begin
    for (int i = 0; i < 21; i++) begin
      tbl[i].run = 1'b1;
      tbl[i].st  = 3'(i / 3);
      tbl[i].adv = (i % 3 == 2) ? 7'(1 << (i / 3)) : 7'd0;
      tbl[i].lap = 8'd0;
    end
    tbl[21] = '{run: 1'b1, st: 3'd0, adv: 7'd0, lap: 8'd1};

    // Default dwell, one full lap against the table
    step(1, 0, 0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 22; i++) begin
      drive(0, tbl[i].run, 0, 0, 0, 0, 0);
      chk($sformatf("tbl%0d state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d adv", i), 32'(bus.adv), 32'(tbl[i].adv));
      chk($sformatf("tbl%0d lap", i), 32'(bus.lap_count), 32'(tbl[i].lap));
      finish_cyc($sformatf("tbl%0d", i));
    end

    // dwell[3]=0, dwell[5]=5: a lap takes 22 cycles
    step(1, 0, 0, 0, 0, 0, 0, "reset2");
    step(0, 0, 1, 3'd3, 4'd0, 0, 0, "cfg3");
    step(0, 0, 1, 3'd5, 4'd5, 0, 0, "cfg5");
    for (int i = 0; i < 21; i++) step(0, 1, 0, 0, 0, 0, 0, "lap22");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("lap22 not yet", 32'(bus.lap_count), 32'd0);
    finish_cyc("lap22");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("lap22 done", 32'(bus.lap_count), 32'd1);
    finish_cyc("lap22");

    // Pause at state 2, cnt 1
    step(1, 0, 0, 0, 0, 0, 0, "reset3");
    run_until(2, 1, -1, 50, "pause");
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("pause adv", 32'(bus.adv), 32'd0);
      chk("pause state", 32'(bus.state), 32'd2);
      finish_cyc("pause");
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("resume adv0", 32'(bus.adv), 32'd0);
    finish_cyc("resume");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("resume adv2", 32'(bus.adv), 32'b100);
    finish_cyc("resume");

    // Illegal next states
    run_until(1, 0, -1, 50, "illegal");
    step(0, 1, 0, 0, 0, 1, 3'd4, "force4");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("force4 state", 32'(bus.state), 32'd4);
    chk("force4 err", 32'(bus.err), 32'd1);
    finish_cyc("force4");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, "sticky");
    step(0, 1, 0, 0, 0, 1, 3'd7, "force7");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("force7 state", 32'(bus.state), 32'd0);
    chk("force7 err", 32'(bus.err), 32'd1);
    finish_cyc("force7");

    // Shrink current dwell below the count
    step(0, 0, 1, 3'd4, 4'd5, 0, 0, "cfg4");
    run_until(4, 3, -1, 80, "shrink");
    step(0, 1, 1, 3'd4, 4'd1, 0, 0, "shrink wr");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("shrink adv4", 32'(bus.adv), 32'b1_0000);
    finish_cyc("shrink");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("shrink state5", 32'(bus.state), 32'd5);
    finish_cyc("shrink");

    // Reset with concurrent cfg write in state 5 after three laps
    run_until(5, 0, 3, 300, "lap3");
    step(1, 1, 1, 3'd0, 4'd9, 0, 0, "rst cfg");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("post rst state", 32'(bus.state), 32'd0);
    chk("post rst lap", 32'(bus.lap_count), 32'd0);
    chk("post rst err", 32'(bus.err), 32'd0);
    finish_cyc("post rst");
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 0, "post rst lap");
    drive(0, 1, 0, 0, 0, 0, 0);
    chk("post rst default lap", 32'(bus.lap_count), 32'd1);
    finish_cyc("post rst lap");

    // Random traffic
    step(1, 0, 0, 0, 0, 0, 0, "reset4");
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)),
           DW'($urandom_range(0, 5)),
           ($urandom_range(0, 59) == 0),
           3'($urandom_range(0, 7)),
           "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
